// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ====================================================================
// regfile_wb_arbiter: merges ALU (A) and load (B) write-backs onto the
// register-file write port and tracks per-register pending bits for RAW
// stalls. Define REGWB_ROUND_ROBIN_EN for round-robin tie-break, else A
// has fixed priority.                                          Rev 1.0
// ====================================================================
module regfile_wb_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [4:0]       a_reg,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [4:0]       b_reg,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             mark_valid,
  input  logic [4:0]       mark_reg,
  input  logic [4:0]       Read1,
  input  logic [4:0]       Read2,
  output logic             stall,
  output logic             RegWrite,
  output logic [4:0]       WriteReg,
  output logic [WIDTH-1:0] WriteData
);

  logic                a_prio;
  logic                grant_a;
  logic                grant_b;
  logic [4:0]          xfer_reg;
  logic [WIDTH-1:0]    xfer_data;
  logic                xfer_write;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

`ifdef REGWB_ROUND_ROBIN_EN
  logic prio_b;

  // Only a contended grant hands priority to the loser.
  always_ff @(posedge clock) begin
    if (reset) begin
      prio_b <= 1'b0;
    end else if (a_valid && b_valid) begin
      prio_b <= grant_a;
    end
  end

  assign a_prio = ~prio_b;
`else
  assign a_prio = 1'b1;
`endif

  assign grant_a = a_valid && (!b_valid || a_prio);
  assign grant_b = b_valid && !grant_a;
  assign a_ready = !reset && grant_a;
  assign b_ready = !reset && grant_b;

  assign xfer_reg   = a_ready ? a_reg  : b_reg;
  assign xfer_data  = a_ready ? a_data : b_data;
  assign xfer_write = (a_ready || b_ready) && (xfer_reg != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= 5'd0;
      WriteData <= '0;
    end else begin
      RegWrite <= xfer_write;
      if (xfer_write) begin
        WriteReg  <= xfer_reg;
        WriteData <= xfer_data;
      end
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (xfer_write) clr_vec[xfer_reg] = 1'b1;
    if (mark_valid && (mark_reg != 5'd0)) set_vec[mark_reg] = 1'b1;
  end

  // Set is applied after clear so a newer producer on the same register wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  assign stall = ((Read1 != 5'd0) && pending[Read1]) ||
                 ((Read2 != 5'd0) && pending[Read2]);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for
// priority-pointer behaviour, then random traffic against a reference model.
module tb_regfile_wb_arbiter;

`ifdef REGWB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, a_valid, b_valid, mark_valid;
  logic [4:0]  a_reg, b_reg, mark_reg, Read1, Read2;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, stall, RegWrite;
  logic [4:0]  WriteReg;
  logic [15:0] WriteData;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.WIDTH(16), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .mark_valid(mark_valid), .mark_reg(mark_reg),
    .Read1(Read1), .Read2(Read2), .stall(stall),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  typedef struct packed {
    logic        rst;
    logic        av;
    logic [4:0]  ar;
    logic [15:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [15:0] bd;
    logic        mv;
    logic [4:0]  mr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        ea;
    logic        eb;
    logic        es;
    logic        ewe;
    logic [4:0]  ewr;
    logic [15:0] ewd;
  } vec_t;

  function automatic vec_t mk(input int rst, av, ar, ad, bv, br, bd, mv, mr,
                              r1, r2, ea, eb, es, ewe, ewr, ewd);
    vec_t v;
    v.rst = 1'(rst); v.av = 1'(av); v.ar = 5'(ar); v.ad = 16'(ad);
    v.bv = 1'(bv); v.br = 5'(br); v.bd = 16'(bd);
    v.mv = 1'(mv); v.mr = 5'(mr); v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.ea = 1'(ea); v.eb = 1'(eb); v.es = 1'(es);
    v.ewe = 1'(ewe); v.ewr = 5'(ewr); v.ewd = 16'(ewd);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic rst, av, input logic [4:0] ar, input logic [15:0] ad,
                       input logic bv, input logic [4:0] br, input logic [15:0] bd,
                       input logic mv, input logic [4:0] mr, r1, r2);
    reset = rst; a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    mark_valid = mv; mark_reg = mr; Read1 = r1; Read2 = r2;
  endtask

  // Inputs applied just after a rising edge, combinational outputs checked at
  // the falling edge, registered outputs checked just after the next rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v.rst, v.av, v.ar, v.ad, v.bv, v.br, v.bd, v.mv, v.mr, v.r1, v.r2);
    @(negedge clock);
    check({tag, " a_ready"}, 32'(a_ready), 32'(v.ea));
    check({tag, " b_ready"}, 32'(b_ready), 32'(v.eb));
    check({tag, " stall"},   32'(stall),   32'(v.es));
    @(posedge clock);
    #1;
    check({tag, " RegWrite"},  32'(RegWrite),  32'(v.ewe));
    check({tag, " WriteReg"},  32'(WriteReg),  32'(v.ewr));
    check({tag, " WriteData"}, 32'(WriteData), 32'(v.ewd));
  endtask

  vec_t tbl[18];

  // Reference model state
  bit          m_pend[32];
  bit          m_prio_b;
  bit          m_we;
  logic [4:0]  m_wr;
  logic [15:0] m_wd;

  initial begin
    //            rst av ar ad       bv br bd       mv mr r1 r2  ea eb es we wr      wd
    tbl[0]  = mk(1, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 5, 'h1234,  0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 1, 5, 'h1234);
    tbl[2]  = mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0, 5, 'h1234);
    tbl[3]  = mk(0, 1, 3, 'h0A03,  1, 7, 'h0B07,  0, 0, 0, 0,  1, 0, 0, 1, 3, 'h0A03);
    tbl[4]  = mk(0, 1, 3, 'h0A03,  1, 7, 'h0B07,  0, 0, 0, 0,  RR ? 0 : 1, RR ? 1 : 0, 0, 1,
                 RR ? 7 : 3, RR ? 'h0B07 : 'h0A03);
    tbl[5]  = mk(0, 1, 3, 'h0A03,  1, 7, 'h0B07,  0, 0, 0, 0,  1, 0, 0, 1, 3, 'h0A03);
    tbl[6]  = mk(0, 1, 3, 'h0A03,  1, 7, 'h0B07,  0, 0, 0, 0,  RR ? 0 : 1, RR ? 1 : 0, 0, 1,
                 RR ? 7 : 3, RR ? 'h0B07 : 'h0A03);
    tbl[7]  = mk(0, 0, 0, 0,       1, 0, 'hBEEF,  0, 0, 0, 0,  0, 1, 0, 0,
                 RR ? 7 : 3, RR ? 'h0B07 : 'h0A03);
    tbl[8]  = mk(0, 0, 0, 0,       0, 0, 0,       1, 9, 9, 0,  0, 0, 0, 0,
                 RR ? 7 : 3, RR ? 'h0B07 : 'h0A03);
    tbl[9]  = mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 9, 0,  0, 0, 1, 0,
                 RR ? 7 : 3, RR ? 'h0B07 : 'h0A03);
    tbl[10] = mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 9, 0,  0, 0, 1, 0,
                 RR ? 7 : 3, RR ? 'h0B07 : 'h0A03);
    tbl[11] = mk(0, 1, 9, 'h0009,  0, 0, 0,       0, 0, 9, 0,  1, 0, 1, 1, 9, 'h0009);
    tbl[12] = mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 9, 0,  0, 0, 0, 0, 9, 'h0009);
    tbl[13] = mk(0, 0, 0, 0,       1, 4, 'h4444,  1, 4, 0, 4,  0, 1, 0, 1, 4, 'h4444);
    tbl[14] = mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 0, 4,  0, 0, 1, 0, 4, 'h4444);
    tbl[15] = mk(0, 0, 0, 0,       0, 0, 0,       1, 2, 0, 0,  0, 0, 0, 0, 4, 'h4444);
    tbl[16] = mk(1, 1, 6, 'h6666,  0, 0, 0,       0, 0, 2, 0,  0, 0, 1, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0,       0, 0, 0,       0, 0, 2, 0,  0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Uncontended grant must not move the round-robin pointer.
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ptr reset");
    run_vec(mk(0, 1, 1, 'h0101, 1, 2, 'h0202, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h0101), "ptr c1");
    run_vec(mk(0, 0, 1, 'h0101, 1, 2, 'h0202, 0, 0, 0, 0, 0, 1, 0, 1, 2, 'h0202), "ptr b");
    run_vec(mk(0, 1, 1, 'h0101, 1, 2, 'h0202, 0, 0, 0, 0, RR ? 0 : 1, RR ? 1 : 0, 0, 1,
               RR ? 2 : 1, RR ? 'h0202 : 'h0101), "ptr c2");
    run_vec(mk(0, 1, 1, 'h0101, 1, 2, 'h0202, 0, 0, 0, 0, 1, 0, 0, 1, 1, 'h0101), "ptr c3");

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      logic        rst, av, bv, mv, ea, eb, es;
      logic [4:0]  ar, br, mr, r1, r2, wreg;
      logic [15:0] ad, bd, wdat;
      rst = (c == 0) || ($urandom_range(0, 49) == 0);
      av = 1'($urandom_range(0, 1)); ar = 5'($urandom_range(0, 7)); ad = 16'($urandom);
      bv = 1'($urandom_range(0, 1)); br = 5'($urandom_range(0, 7)); bd = 16'($urandom);
      mv = 1'($urandom_range(0, 1)); mr = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));

      ea = 1'b0; eb = 1'b0;
      if (!rst) begin
        if (av && bv) begin
          if (m_prio_b) eb = 1'b1; else ea = 1'b1;
        end else begin
          ea = av; eb = bv;
        end
      end
      es = ((r1 != 0) && m_pend[r1]) || ((r2 != 0) && m_pend[r2]);

      drive(rst, av, ar, ad, bv, br, bd, mv, mr, r1, r2);
      @(negedge clock);
      check($sformatf("rnd%0d a_ready", c), 32'(a_ready), 32'(ea));
      check($sformatf("rnd%0d b_ready", c), 32'(b_ready), 32'(eb));
      check($sformatf("rnd%0d stall", c),   32'(stall),   32'(es));

      if (rst) begin
        for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
        m_prio_b = 1'b0; m_we = 1'b0; m_wr = 5'd0; m_wd = 16'd0;
      end else begin
        wreg = ea ? ar : br;
        wdat = ea ? ad : bd;
        if ((ea || eb) && (wreg != 0)) begin
          m_we = 1'b1; m_wr = wreg; m_wd = wdat; m_pend[wreg] = 1'b0;
        end else begin
          m_we = 1'b0;
        end
        if (mv && (mr != 0)) m_pend[mr] = 1'b1;
        if (RR && av && bv) m_prio_b = ea;
      end

      @(posedge clock);
      #1;
      check($sformatf("rnd%0d RegWrite", c),  32'(RegWrite),  32'(m_we));
      check($sformatf("rnd%0d WriteReg", c),  32'(WriteReg),  32'(m_wr));
      check($sformatf("rnd%0d WriteData", c), 32'(WriteData), 32'(m_wd));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry register file. It merges two write-back requesters, ALU result (A) and memory load (B), onto the register file's single write port (`RegWrite`/`WriteReg`/`WriteData`). It also keeps a per-register pending bit so the decode stage can stall on read-after-write hazards. The block sits between the execute/memory stages and `registrador`, and owns that module's write port.

## Interface
- `WIDTH`, 16: write-data width; must match the register file `WIDTH`.
- `NUM_REGS`, 32: register count; register index is 5 bits.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A has a write pending.
- `a_reg`  in  5  A destination register.
- `a_data`  in  WIDTH  A write data.
- `a_ready`  out  1  A accepted this cycle.
- `b_valid`, `b_reg`, `b_data`, `b_ready`: same as A, for requester B.
- `mark_valid`  in  1  decode issued an instruction with a destination.
- `mark_reg`  in  5  that destination; sets its pending bit.
- `Read1`, `Read2`  in  5  decode source registers.
- `stall`  out  1  combinational: a nonzero source has its pending bit set.
- `RegWrite`  out  1  registered write enable to the register file.
- `WriteReg`  out  5  registered write index.
- `WriteData`  out  WIDTH  registered write data.

## Operation
- Transfer rule: a transfer happens when `x_valid && x_ready`. At most one transfer per cycle.
- `x_ready` is combinational from the grant only; it never depends on `x_data`.
- Grant rules:
  - Only one requester valid: that requester is granted.
  - Both valid: the priority holder is granted (see Configuration).
  - Neither valid: both readys are 0.
- Accepted transfer with `x_reg != 0`:
  - Next cycle: `RegWrite=1`, `WriteReg=x_reg`, `WriteData=x_data`.
  - `pending[x_reg]` clears at the same edge.
- Accepted transfer with `x_reg == 0`: the handshake completes, but `RegWrite` stays 0 and the pending bits are unchanged.
- No transfer: the next cycle has `RegWrite=0`. `WriteReg`/`WriteData` hold their previous values.
- Scoreboard: a 32-bit `pending` vector.
  - `mark_valid && mark_reg != 0` sets `pending[mark_reg]`.
  - Register 0 is never pending.
- Same edge set and clear on the same register: the set wins, because a newer producer is outstanding.
- Different registers set and cleared on the same edge: both take effect.
- `stall = (Read1!=0 && pending[Read1]) || (Read2!=0 && pending[Read2])`. There is no bypass; a cleared bit is visible the cycle after the write edge.
- A requester whose valid is not accepted must hold valid and its payload stable. The arbiter does not buffer.

## Timing
- Reset (synchronous, takes effect at the edge with `reset=1`):
  - `RegWrite=0`, `WriteReg=0`, `WriteData=0`.
  - `pending=0`.
  - Round-robin priority set to A.
- `a_ready`/`b_ready` are 0 whenever `reset=1`.
- Latency: handshake in cycle N gives the register-file write at edge N+1→N+2, so the data is readable from cycle N+2.
- Throughput: one write per cycle, sustained.
- Reset mid-operation: a transfer in the reset cycle is dropped, and all pending bits clear. Upstream re-issues.
- State machine: none beyond the 1-bit priority pointer. Idle is `RegWrite=0`; active is `RegWrite=1`; the transition is a transfer with a nonzero register.

## Configuration
- `REGWB_ROUND_ROBIN_EN` defined:
  - 1-bit pointer; after granting X under contention, priority moves to the other requester.
  - Uncontended grants leave the pointer unchanged.
- Not defined:
  - Fixed priority: A always wins a tie, so B may starve.
  - No pointer flop.

## Test plan
- Reset, then A only: `a_reg=5`, `a_data=16'h1234` in cycle 1 → `a_ready=1` in cycle 1; cycle 2 shows `RegWrite=1`, `WriteReg=5`, `WriteData=16'h1234`; cycle 3 shows `RegWrite=0`.
- Contention for 4 cycles, A→r3 and B→r7 both valid, with RR enabled → grants A,B,A,B. With RR disabled → A every cycle, `b_ready=0` throughout.
- Write to r0 from B → `b_ready=1`, next cycle `RegWrite=0`, pending unchanged.
- Scoreboard: mark r9 in cycle 1 → `stall=1` with `Read1=9` in cycle 2. Write r9 in cycle 4 → `stall=0` in cycle 5.
- Same-edge mark r4 and write r4 → `pending[4]=1` afterwards, `stall` stays 1 for `Read2=4`.
- Reset asserted while A is valid and r2 is pending → no `RegWrite` the next cycle, `pending=0`, `stall=0`.
